instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Encoder/loader for the 12-bit processor instruction word; the write-side counterpart of the control-unit decoder.
- Accepts instruction fields (op, d, s1, s2, imm) over a valid/ready handshake and packs them into the 12-bit format.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory at an auto-incrementing address.
- Sits between the program loader/debug port and the instruction memory.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 8, instruction-memory address width; address wraps at 2^ADDR_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  field set present.
- in_ready  output  1  FIFO can accept; equals !full.
- in_op  input  3  opcode.
- in_d  input  3  destination register.
- in_s1  input  3  source register 1.
- in_s2  input  3  source register 2.
- in_imm  input  8  immediate.
- start  input  1  restart the load at address 0.
- imem_we  output  1  write request; equals !empty.
- imem_ready  input  1  memory accepts the write this cycle.
- imem_addr  output  ADDR_W  write address (register).
- imem_wdata  output  12  FIFO head word.
- addr_wrap  output  1  one-cycle pulse when the address wraps from max to 0.
- err  output  1  sticky field-misuse flag (optional feature only; tied 0 otherwise).

Behaviour:
- Encoding:
  - Immediate forms are op 3'b110 (jump) and 3'b011 (load). Word = {in_imm, 1'b0, in_op}; d, s1 and s2 are ignored.
  - All other ops use register form. Word = {in_s2, in_s1, in_d, in_op}; imm is ignored.
- Accept: a word is accepted when in_valid && in_ready at the clock edge. The encoded word is pushed on that edge.
- in_ready is combinational from the occupancy count only.
- A push is refused while full, even if a pop happens in the same cycle.
- Write: a write occurs when imem_we && imem_ready.
  - On that edge, pop the head and increment imem_addr.
  - imem_wdata is stable while imem_we is high and imem_ready is low.
- Latency: a word accepted at edge N appears as imem_we=1 in the cycle after edge N. No bypass while empty.
- Simultaneous push and pop (not full, not empty): occupancy is unchanged and order is preserved.
- Address wrap: an increment from 2^ADDR_W-1 gives 0, and addr_wrap=1 for exactly the following cycle.
- start:
  - The next imem_addr is 0.
  - If a write occurs in the same cycle, that write uses the current address, then imem_addr becomes 0.
  - FIFO contents are kept.
  - start overrides wrap: no addr_wrap pulse.
- Reset (rst_n=0 at an edge, including mid-drain):
  - FIFO is emptied and queued words are lost.
  - imem_addr=0, imem_we=0, in_ready=1, addr_wrap=0, err=0.
  - Inputs are ignored during that edge.

Optional Feature:
- Macro ENC_FIELD_CHECK_EN.
- When defined, err is set on an accept if either condition holds:
  - immediate form with any of in_d, in_s1, in_s2 nonzero;
  - register form with in_imm nonzero.
- err stays set until reset. Words are still encoded and written normally.
- When not defined, err is constant 0 and no check logic exists.

Test Plan:
- Register form: op=3'b001, d=2, s1=5, s2=7, imem_ready=1 → one cycle later imem_we=1, imem_wdata=12'hF51, imem_addr=0; next cycle imem_addr=1.
- Immediate forms: op=3'b110, imm=8'hA5, d=7 → 12'hA56; then op=3'b011, imm=8'h3C → 12'h3C3, written at consecutive addresses.
- Backpressure/full (DEPTH=4):
  - Hold imem_ready=0 and offer 5 words; in_ready drops after the 4th and the 5th is held.
  - Raise imem_ready; all 5 words are written in order at addresses 0–4, with no loss or duplication.
- Wrap (ADDR_W=4): write 17 words continuously → 16th at address 15, 17th at address 0, addr_wrap high for exactly one cycle.
- start and reset:
  - start asserted during the write at address 6 → that word is at 6 and the next word at 0.
  - rst_n=0 with 3 words queued → next cycle imem_we=0, in_ready=1, imem_addr=0.
- ENC_FIELD_CHECK_EN defined:
  - op=3'b110, imm=8'h01, d=1 → word 12'h016 is still written and err=1 persists.
  - Without the macro, the same stimulus leaves err=0.

Source files
------------

// File: rtl/instr_encode_loader.sv
// Packs 12-bit instruction words from field sets, queues them in a small FIFO and
// streams them into instruction memory at an auto-incrementing address.
// Optional build macro ENC_FIELD_CHECK_EN enables the sticky field-misuse flag (err).
module instr_encode_loader #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [2:0]        in_d,
    input  logic [2:0]        in_s1,
    input  logic [2:0]        in_s2,
    input  logic [7:0]        in_imm,
    input  logic              start,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [11:0]       imem_wdata,
    output logic              addr_wrap,
    output logic              err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Jump (110) and load (011) carry an 8-bit immediate instead of register fields.
    function automatic logic is_imm_form(input logic [2:0] op);
        return (op == 3'b110) || (op == 3'b011);
    endfunction

    function automatic logic [11:0] encode(input logic [2:0] op, input logic [2:0] d,
                                           input logic [2:0] s1, input logic [2:0] s2,
                                           input logic [7:0] imm);
        if (is_imm_form(op))
            return {imm, 1'b0, op};
        else
            return {s2, s1, d, op};
    endfunction

    logic [11:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrap_q, wrap_d;
    logic              push, pop;
    logic [11:0]       enc_word;

    always_comb begin
        push     = in_valid && (count_q != FULL_CNT);
        pop      = (count_q != '0) && imem_ready;
        enc_word = encode(in_op, in_d, in_s1, in_s2, in_imm);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        wrap_d   = 1'b0;

        if (push)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // start wins over the increment; a same-cycle write still used addr_q.
        if (start) begin
            addr_d = '0;
        end else if (pop) begin
            addr_d = addr_q + ADDR_W'(1);
            wrap_d = (addr_q == {ADDR_W{1'b1}});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            wrap_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            wrap_q   <= wrap_d;
        end
    end

    // Storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem_q[wr_ptr_q] <= enc_word;
    end

`ifdef ENC_FIELD_CHECK_EN
    logic err_q, err_d;
    logic misuse;

    always_comb begin
        if (is_imm_form(in_op))
            misuse = (in_d != 3'd0) || (in_s1 != 3'd0) || (in_s2 != 3'd0);
        else
            misuse = (in_imm != 8'd0);
        err_d = err_q || (push && misuse);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready   = (count_q != FULL_CNT);
    assign imem_we    = (count_q != '0);
    assign imem_wdata = mem_q[rd_ptr_q];
    assign imem_addr  = addr_q;
    assign addr_wrap  = wrap_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader (DEPTH=4, ADDR_W=4) with hand-computed expectations.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op, in_d, in_s1, in_s2;
    logic [7:0]  in_imm;
    logic        start;
    logic        imem_we;
    logic        imem_ready;
    logic [3:0]  imem_addr;
    logic [11:0] imem_wdata;
    logic        addr_wrap;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

`ifdef ENC_FIELD_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    instr_encode_loader #(.DEPTH(4), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_d       (in_d),
        .in_s1      (in_s1),
        .in_s2      (in_s2),
        .in_imm     (in_imm),
        .start      (start),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .addr_wrap  (addr_wrap),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [7:0] imm);
        in_valid = 1'b1;
        in_op    = op;
        in_d     = d;
        in_s1    = s1;
        in_s2    = s2;
        in_imm   = imm;
    endtask

    logic [11:0] bpw [5];
    logic        acc;

    initial begin
        bpw = '{12'h8C2, 12'h8CA, 12'h8D2, 12'h8DA, 12'h8E2};
        rst_n = 1'b0; in_valid = 1'b0; start = 1'b0; imem_ready = 1'b0;
        in_op = 3'd0; in_d = 3'd0; in_s1 = 3'd0; in_s2 = 3'd0; in_imm = 8'd0;
        tick();
        tick();
        chk("rst_we",    32'(imem_we),   32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        chk("rst_addr",  32'(imem_addr), 32'd0);
        chk("rst_wrap",  32'(addr_wrap), 32'd0);
        chk("rst_err",   32'(err),       32'd0);

        // Register form
        rst_n = 1'b1; imem_ready = 1'b1;
        drive(3'b001, 3'd2, 3'd5, 3'd7, 8'h00);
        tick();
        in_valid = 1'b0;
        chk("reg_we",    32'(imem_we),    32'd1);
        chk("reg_wdata", 32'(imem_wdata), 32'hF51);
        chk("reg_addr",  32'(imem_addr),  32'd0);
        tick();
        chk("reg_addr_inc", 32'(imem_addr), 32'd1);
        chk("reg_we_idle",  32'(imem_we),   32'd0);

        // Immediate forms back to back
        drive(3'b110, 3'd7, 3'd0, 3'd0, 8'hA5);
        tick();
        chk("jmp_we",    32'(imem_we),    32'd1);
        chk("jmp_wdata", 32'(imem_wdata), 32'hA56);
        chk("jmp_addr",  32'(imem_addr),  32'd1);
        drive(3'b011, 3'd0, 3'd0, 3'd0, 8'h3C);
        tick();
        in_valid = 1'b0;
        chk("ld_we",    32'(imem_we),    32'd1);
        chk("ld_wdata", 32'(imem_wdata), 32'h3C3);
        chk("ld_addr",  32'(imem_addr),  32'd2);
        tick();
        chk("ld_addr_inc", 32'(imem_addr), 32'd3);
        chk("ld_we_idle",  32'(imem_we),   32'd0);
        chk("err_after_jmp", 32'(err), 32'(ERR_EXP));

        // Immediate form with a stray register field
        drive(3'b110, 3'd1, 3'd0, 3'd0, 8'h01);
        tick();
        in_valid = 1'b0;
        chk("misuse_wdata", 32'(imem_wdata), 32'h016);
        chk("misuse_addr",  32'(imem_addr),  32'd3);
        tick();
        chk("misuse_addr_inc", 32'(imem_addr), 32'd4);
        chk("misuse_err",      32'(err),       32'(ERR_EXP));

        // Backpressure: fill while memory stalls, then drain
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_addr", 32'(imem_addr), 32'd0);
        chk("start_wrap", 32'(addr_wrap), 32'd0);
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(3'b010, 3'(i), 3'd3, 3'd4, 8'hFF);
            chk("bp_ready", 32'(in_ready), 32'(i < 4));
            tick();
        end
        chk("bp_hold_we",    32'(imem_we),    32'd1);
        chk("bp_hold_wdata", 32'(imem_wdata), 32'h8C2);
        chk("bp_full",       32'(in_ready),   32'd0);
        imem_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk("drain_we",    32'(imem_we),    32'd1);
            chk("drain_wdata", 32'(imem_wdata), 32'(bpw[j]));
            chk("drain_addr",  32'(imem_addr),  32'(j));
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        chk("drain_empty", 32'(imem_we),   32'd0);
        chk("drain_addr5", 32'(imem_addr), 32'd5);

        // Address wrap over 17 continuous writes
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wrap_start_addr", 32'(imem_addr), 32'd0);
        for (int c = 1; c <= 18; c++) begin
            if (c <= 17) drive(3'b100, 3'(c - 1), 3'd0, 3'd0, 8'h00);
            else in_valid = 1'b0;
            tick();
            if (c <= 17) begin
                chk("wrap_addr",  32'(imem_addr),  32'((c - 1) % 16));
                chk("wrap_wdata", 32'(imem_wdata), 32'((((c - 1) % 8) * 8) + 4));
                chk("wrap_we",    32'(imem_we),    32'd1);
            end
            chk("wrap_pulse", 32'(addr_wrap), 32'(c == 17));
        end
        chk("wrap_end_we",   32'(imem_we),   32'd0);
        chk("wrap_end_addr", 32'(imem_addr), 32'd1);

        // start during the write at address 6
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) drive(3'b101, 3'(c - 1), 3'd0, 3'd0, 8'h00);
            else in_valid = 1'b0;
            if (c == 8) start = 1'b1;
            tick();
            start = 1'b0;
            if (c == 7) begin
                chk("st_addr6",  32'(imem_addr),  32'd6);
                chk("st_wdata6", 32'(imem_wdata), 32'h035);
            end
            if (c == 8) begin
                chk("st_addr0",  32'(imem_addr),  32'd0);
                chk("st_wdata7", 32'(imem_wdata), 32'h03D);
                chk("st_nowrap", 32'(addr_wrap),  32'd0);
            end
            if (c == 9) begin
                chk("st_end_we",   32'(imem_we),   32'd0);
                chk("st_end_addr", 32'(imem_addr), 32'd1);
            end
        end

        // Reset with three words queued
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(3'b001, 3'd1, 3'd1, 3'd1, 8'h00);
            tick();
        end
        in_valid = 1'b0;
        chk("q3_we",   32'(imem_we),   32'd1);
        chk("q3_addr", 32'(imem_addr), 32'd1);
        rst_n = 1'b0; imem_ready = 1'b1;
        drive(3'b001, 3'd2, 3'd2, 3'd2, 8'h00);
        tick();
        chk("mrst_we",    32'(imem_we),   32'd0);
        chk("mrst_ready", 32'(in_ready),  32'd1);
        chk("mrst_addr",  32'(imem_addr), 32'd0);
        chk("mrst_wrap",  32'(addr_wrap), 32'd0);
        chk("mrst_err",   32'(err),       32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        chk("post_rst_we", 32'(imem_we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
